mem_port_arbiter: RTL

Shares the single-port unified memory between three requesters: instruction fetch (IF), data load/store (D), and an external program loader (LD). It also decodes the memory-mapped I/O window that holds the LED, HEX and switch registers. The block sits between the RISC-V core, the loader and the memory array. It drives the array's asynchronous-read / synchronous-write port, grants at most one access per cycle, and returns read data one cycle after the grant.

---
 rtl/mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between three requesters:
// instruction fetch (IF), data load/store (D) and the external program
// loader (LD). The block also decodes the memory-mapped I/O window that
// holds the LED, HEX and switch registers.
//
// At most one access is granted per cycle. Grants are combinational from
// the requests and a 1-bit round-robin register. Read data is returned one
// cycle after the grant, on a separate response register per requester.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt          fetch request (read only)
//   if_rvalid/if_rdata                fetch response, one cycle after grant
//   d_req/d_we/d_addr/d_wdata -> d_gnt  data request
//   d_rvalid/d_rdata                  data read response
//   ld_req/ld_addr/ld_wdata -> ld_gnt loader request (write only)
//   mem_we/mem_a/mem_wd, mem_rd       memory array port (async read,
//                                     sync write)
//   sw                                board switches (asynchronous)
//   led, hex                          IO output registers
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] LED_ADDR  = 32'h104,
  parameter logic [31:0] HEX_ADDR  = 32'h108,
  parameter logic [31:0] SW_ADDR   = 32'h120
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,

  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,

  input  logic [9:0]  sw,
  output logic [9:0]  led,
  output logic [31:0] hex
);

  // Grant selector encoding.
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_IF   = 2'd1;
  localparam logic [1:0] SEL_D    = 2'd2;
  localparam logic [1:0] SEL_LD   = 2'd3;

  // First byte address past the RAM region (33 bits so MEM_WORDS*4 can
  // reach 2^32 without wrapping).
  localparam logic [32:0] RAM_LIMIT = 33'(MEM_WORDS) << 2;

  // Word-aligned IO register addresses.
  localparam logic [31:0] LED_WORD = {LED_ADDR[31:2], 2'b00};
  localparam logic [31:0] HEX_WORD = {HEX_ADDR[31:2], 2'b00};
  localparam logic [31:0] SW_WORD  = {SW_ADDR[31:2], 2'b00};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic        rr_last_d_reg;   // 1: D was the last IF/D winner
  logic        rr_last_d_next;
  logic        if_rvalid_reg;
  logic [31:0] if_rdata_reg;
  logic        d_rvalid_reg;
  logic [31:0] d_rdata_reg;
  logic [9:0]  led_reg;
  logic [31:0] hex_reg;
  logic [9:0]  sw_meta_reg;     // first synchronizer stage
  logic [9:0]  sw_sync_reg;     // second synchronizer stage

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [1:0]  sel;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic        gnt_we;

  always_comb begin
    sel = SEL_NONE;
    // Grants are forced low while reset is asserted so every output sits
    // at its reset value independent of the request inputs.
    if (!reset_n) begin
      sel = SEL_NONE;
    end else if (ld_req) begin
      sel = SEL_LD;
    end else if (if_req && d_req) begin
      // On conflict the requester that did not win last time goes now.
      sel = rr_last_d_reg ? SEL_IF : SEL_D;
    end else if (if_req) begin
      sel = SEL_IF;
    end else if (d_req) begin
      sel = SEL_D;
    end
  end

  assign if_gnt = (sel == SEL_IF);
  assign d_gnt  = (sel == SEL_D);
  assign ld_gnt = (sel == SEL_LD);

  always_comb begin
    gnt_addr  = 32'h0;
    gnt_wdata = 32'h0;
    gnt_we    = 1'b0;
    case (sel)
      SEL_IF: begin
        gnt_addr = if_addr;
      end
      SEL_D: begin
        gnt_addr  = d_addr;
        gnt_wdata = d_wdata;
        gnt_we    = d_we;
      end
      SEL_LD: begin
        gnt_addr  = ld_addr;
        gnt_wdata = ld_wdata;
        gnt_we    = 1'b1;
      end
      default: begin
        gnt_addr  = 32'h0;
        gnt_wdata = 32'h0;
        gnt_we    = 1'b0;
      end
    endcase
  end

  // The loader does not disturb the IF/D fairness history.
  always_comb begin
    rr_last_d_next = rr_last_d_reg;
    if (sel == SEL_IF) begin
      rr_last_d_next = 1'b0;
    end else if (sel == SEL_D) begin
      rr_last_d_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Address decode on the granted address (byte offset ignored)
  // ---------------------------------------------------------------------
  logic [31:0] word_addr;
  logic        in_io;
  logic        hit_led;
  logic        hit_hex;
  logic        hit_sw;
  logic        hit_ram;

  assign word_addr = {gnt_addr[31:2], 2'b00};
  assign in_io     = (word_addr[31:8] == 24'h000001);   // 0x100..0x1FF
  assign hit_led   = in_io && (word_addr == LED_WORD);
  assign hit_hex   = in_io && (word_addr == HEX_WORD);
  assign hit_sw    = in_io && (word_addr == SW_WORD);
  // IO window shadows any RAM underneath it.
  assign hit_ram   = !in_io && ({1'b0, word_addr} < RAM_LIMIT);

  // ---------------------------------------------------------------------
  // Memory port
  // ---------------------------------------------------------------------
  assign mem_a  = gnt_addr;
  assign mem_wd = gnt_wdata;
  assign mem_we = gnt_we && hit_ram;

  // ---------------------------------------------------------------------
  // Read data selection for the granted read
  // ---------------------------------------------------------------------
  logic [31:0] rd_data;

  always_comb begin
    rd_data = 32'h0;
    if (hit_ram) begin
      rd_data = mem_rd;
    end else if (hit_led) begin
      rd_data = {22'b0, led_reg};
    end else if (hit_hex) begin
      rd_data = hex_reg;
    end else if (hit_sw) begin
      rd_data = {22'b0, sw_sync_reg};
    end
  end

  logic if_rd_gnt;
  logic d_rd_gnt;
  logic led_wr;
  logic hex_wr;

  assign if_rd_gnt = (sel == SEL_IF);
  assign d_rd_gnt  = (sel == SEL_D) && !d_we;
  // Writes to SW_ADDR or unmapped addresses fall through and are dropped.
  assign led_wr    = gnt_we && hit_led;
  assign hex_wr    = gnt_we && hit_hex;

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_d_reg <= 1'b0;
      if_rvalid_reg <= 1'b0;
      if_rdata_reg  <= 32'h0;
      d_rvalid_reg  <= 1'b0;
      d_rdata_reg   <= 32'h0;
      led_reg       <= 10'h0;
      hex_reg       <= 32'h0;
      sw_meta_reg   <= 10'h0;
      sw_sync_reg   <= 10'h0;
    end else begin
      rr_last_d_reg <= rr_last_d_next;

      // rvalid pulses for exactly the cycle after each granted read;
      // rdata holds until the next read for the same requester.
      if_rvalid_reg <= if_rd_gnt;
      if (if_rd_gnt) begin
        if_rdata_reg <= rd_data;
      end

      d_rvalid_reg <= d_rd_gnt;
      if (d_rd_gnt) begin
        d_rdata_reg <= rd_data;
      end

      if (led_wr) begin
        led_reg <= gnt_wdata[9:0];
      end
      if (hex_wr) begin
        hex_reg <= gnt_wdata;
      end

      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign d_rdata   = d_rdata_reg;
  assign led       = led_reg;
  assign hex       = hex_reg;

endmodule
